// File: rtl/layer_engine.sv
// layer_engine: fully-connected layer with fixed-point activation.
// Sweeps a weight RAM to run a forward pass, an input-gradient back-propagation,
// or a back-propagation followed by an in-place weight/bias update.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enable              clock-enable; low freezes all state and outputs
//   cmd, start          operation (0 fwd, 1 grad, 2 grad+update, 3 = fwd) and strobe
//   ready_in            neighbour data valid; gates the start of a sweep
//   inputs_f, inputs_b  layer inputs and output errors, packed NUM_W per element
//   output_f, output_b  activated outputs and input gradients, packed
//   ram_*               one read port (RAM_DELAY latency) and one write port
//   ready_out, done     idle indicator and one-cycle completion pulse
//   sat_flag            sticky saturation indicator for the current command
module layer_engine #(
  parameter int INT_W          = 8,
  parameter int FRAC_W         = 8,
  parameter int NUM_W          = INT_W + FRAC_W,
  parameter int INPUTS         = 2,
  parameter int OUTPUTS        = 1,
  parameter int RAM_ADDR_W     = 8,
  parameter int RAM_ADDR_START = 0,
  parameter int RAM_DELAY      = 3,
  parameter int ACT_MODE       = 1,
  parameter int RELU_SHIFT     = 4,
  parameter int RELU_MAX       = 4,
  parameter int LR_SHIFT       = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [1:0]                  cmd,
  input  logic                        start,
  input  logic                        ready_in,
  input  logic [INPUTS*NUM_W-1:0]     inputs_f,
  input  logic [OUTPUTS*NUM_W-1:0]    inputs_b,
  output logic [OUTPUTS*NUM_W-1:0]    output_f,
  output logic [INPUTS*NUM_W-1:0]     output_b,
  output logic [RAM_ADDR_W-1:0]       ram_addr_read,
  input  logic [NUM_W-1:0]            ram_data_read,
  output logic                        ram_write,
  output logic [RAM_ADDR_W-1:0]       ram_addr_write,
  output logic [NUM_W-1:0]            ram_data_write,
  output logic                        ready_out,
  output logic                        done,
  output logic                        sat_flag
);

  typedef logic signed [NUM_W-1:0] num_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SWEEP, S_UPDATE, S_DONE} state_t;
  typedef enum logic [1:0] {OP_FWD, OP_GRAD, OP_TRAIN} op_t;

  localparam int N    = OUTPUTS * (INPUTS + 1);   // RAM words per sweep
  localparam int LAST = N + RAM_DELAY;            // final cycle index of a sweep
  localparam int CW   = $clog2(LAST + 2);
  localparam int IW   = $clog2(INPUTS + 1);
  localparam int NW   = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  localparam num_t NUM_MAX = {1'b0, {(NUM_W-1){1'b1}}};
  localparam num_t NUM_MIN = {1'b1, {(NUM_W-1){1'b0}}};
  localparam num_t KNEE    = num_t'(RELU_MAX << FRAC_W);
  localparam logic [RAM_ADDR_W-1:0] ADDR0 = RAM_ADDR_W'(RAM_ADDR_START);
  localparam logic [CW-1:0] CYC_FIRST_USE = CW'(RAM_DELAY);
  localparam logic [CW-1:0] CYC_LAST_USE  = CW'(N - 1 + RAM_DELAY);
  localparam logic [CW-1:0] CYC_LAST_ISS  = CW'(N - 1);
  localparam logic [CW-1:0] CYC_LAST      = CW'(LAST);

  // Saturating arithmetic; bit NUM_W of the result reports a saturation.
  function automatic logic [NUM_W:0] sat_add(input num_t a, input num_t b);
    logic [NUM_W:0] s;
    s = {a[NUM_W-1], a} + {b[NUM_W-1], b};
    if (s[NUM_W] != s[NUM_W-1]) return {1'b1, (s[NUM_W] ? NUM_MIN : NUM_MAX)};
    return {1'b0, s[NUM_W-1:0]};
  endfunction

  function automatic logic [NUM_W:0] sat_mul(input num_t a, input num_t b);
    logic signed [2*NUM_W-1:0] aw, bw, prod;
    aw   = {{NUM_W{a[NUM_W-1]}}, a};
    bw   = {{NUM_W{b[NUM_W-1]}}, b};
    prod = aw * bw;
    prod = prod >>> FRAC_W;
    // In range only if every bit above the result sign matches it.
    if (prod[2*NUM_W-1:NUM_W-1] != '0 && prod[2*NUM_W-1:NUM_W-1] != '1)
      return {1'b1, (prod[2*NUM_W-1] ? NUM_MIN : NUM_MAX)};
    return {1'b0, prod[NUM_W-1:0]};
  endfunction

  function automatic num_t activate(input num_t v);
    if (ACT_MODE == 1) begin
      if (v > KNEE)      return ((v - KNEE) >>> RELU_SHIFT) + KNEE;
      if (v[NUM_W-1])    return v >>> RELU_SHIFT;
    end
    return v;
  endfunction

  state_t state, state_n;
  op_t    op, cmd_op;
  num_t   p  [OUTPUTS];       // stored pre-activations
  num_t   ob [INPUTS];        // input-gradient accumulators
  num_t   x  [INPUTS];
  num_t   eb [OUTPUTS];
  logic [CW-1:0]         cyc;       // cycle index within a sweep
  logic [IW-1:0]         cn_w;      // word within neuron of the word being consumed
  logic [NW-1:0]         cn_n;      // neuron of the word being consumed
  logic [RAM_ADDR_W-1:0] cn_addr;   // address of the word being consumed

  num_t rd, sel_x, sel_p, sel_eb, sel_ob, err, fwd_term, upd_prod, upd_delta;
  logic [NUM_W:0] fwd_mul, fwd_sum, bwd_mul, bwd_sum, upd_mul, upd_sum;
  logic is_bias, consume, step_sat;

  assign cmd_op  = (cmd == 2'd1) ? OP_GRAD : (cmd == 2'd2) ? OP_TRAIN : OP_FWD;
  assign rd      = ram_data_read;
  assign consume = (state == S_SWEEP || state == S_UPDATE) &&
                   cyc >= CYC_FIRST_USE && cyc <= CYC_LAST_USE;

  always_comb begin
    for (int i = 0; i < INPUTS; i++)  x[i]  = inputs_f[i*NUM_W +: NUM_W];
    for (int n = 0; n < OUTPUTS; n++) eb[n] = inputs_b[n*NUM_W +: NUM_W];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset)       state <= S_IDLE;
    else if (enable) state <= state_n;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_n   = state;
    ready_out = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (start) state_n = S_WAIT;
      end
      S_WAIT:   if (ready_in) state_n = S_SWEEP;
      S_SWEEP:  if (cyc == CYC_LAST) state_n = (op == OP_TRAIN) ? S_UPDATE : S_DONE;
      S_UPDATE: if (cyc == CYC_LAST) state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Per-word arithmetic for the word currently arriving from the RAM.
  always_comb begin
    sel_x  = '0;
    sel_ob = '0;
    sel_p  = '0;
    sel_eb = '0;
    for (int i = 0; i < INPUTS; i++)
      if (cn_w == IW'(i)) begin
        sel_x  = x[i];
        sel_ob = ob[i];
      end
    for (int n = 0; n < OUTPUTS; n++)
      if (cn_n == NW'(n)) begin
        sel_p  = p[n];
        sel_eb = eb[n];
      end
    is_bias = (cn_w == IW'(INPUTS));
    // Outside the unit-slope region the error is scaled by the leak slope.
    err = ((ACT_MODE == 1) && (sel_p[NUM_W-1] || sel_p > KNEE)) ? (sel_eb >>> RELU_SHIFT) : sel_eb;

    fwd_mul  = sat_mul(rd, sel_x);
    fwd_term = is_bias ? rd : num_t'(fwd_mul[NUM_W-1:0]);
    fwd_sum  = sat_add(sel_p, fwd_term);

    bwd_mul  = sat_mul(rd, err);
    bwd_sum  = sat_add(sel_ob, num_t'(bwd_mul[NUM_W-1:0]));

    upd_mul   = sat_mul(sel_x, err);
    upd_prod  = upd_mul[NUM_W-1:0];
    upd_delta = is_bias ? (err >>> LR_SHIFT) : (upd_prod >>> LR_SHIFT);
    upd_sum   = sat_add(rd, upd_delta);

    if (state == S_UPDATE) step_sat = upd_sum[NUM_W] | (!is_bias & upd_mul[NUM_W]);
    else if (op == OP_FWD) step_sat = fwd_sum[NUM_W] | (!is_bias & fwd_mul[NUM_W]);
    else                   step_sat = !is_bias & (bwd_mul[NUM_W] | bwd_sum[NUM_W]);
  end

  // Datapath, counters and RAM port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: p and ob are small register arrays, not RAM, so they are reset
      // explicitly; output_f must read as the activation of zero after reset.
      for (int n = 0; n < OUTPUTS; n++) p[n] <= '0;
      for (int i = 0; i < INPUTS; i++)  ob[i] <= '0;
      sat_flag       <= 1'b0;
      ram_write      <= 1'b0;
      ram_addr_read  <= '0;
      ram_addr_write <= '0;
      ram_data_write <= '0;
      op             <= OP_FWD;
      cyc            <= '0;
      cn_w           <= '0;
      cn_n           <= '0;
      cn_addr        <= '0;
    end else if (enable) begin
      ram_write <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op       <= cmd_op;
          sat_flag <= 1'b0;
          if (cmd_op == OP_FWD) for (int n = 0; n < OUTPUTS; n++) p[n] <= '0;
          else                  for (int i = 0; i < INPUTS; i++)  ob[i] <= '0;
        end
        S_WAIT: begin
          ram_addr_read <= ADDR0;
          cyc           <= '0;
          cn_w          <= '0;
          cn_n          <= '0;
          cn_addr       <= ADDR0;
        end
        S_SWEEP, S_UPDATE: begin
          cyc <= cyc + CW'(1);
          if (cyc < CYC_LAST_ISS) ram_addr_read <= ram_addr_read + RAM_ADDR_W'(1);
          if (consume) begin
            cn_addr <= cn_addr + RAM_ADDR_W'(1);
            if (is_bias) begin
              cn_w <= '0;
              cn_n <= cn_n + NW'(1);
            end else begin
              cn_w <= cn_w + IW'(1);
            end
            if (step_sat) sat_flag <= 1'b1;
            if (state == S_UPDATE) begin
              // Written back the cycle after the word arrives, same address.
              ram_write      <= 1'b1;
              ram_addr_write <= cn_addr;
              ram_data_write <= upd_sum[NUM_W-1:0];
            end else if (op == OP_FWD) begin
              for (int n = 0; n < OUTPUTS; n++)
                if (cn_n == NW'(n)) p[n] <= fwd_sum[NUM_W-1:0];
            end else if (!is_bias) begin
              for (int i = 0; i < INPUTS; i++)
                if (cn_w == IW'(i)) ob[i] <= bwd_sum[NUM_W-1:0];
            end
          end
          // Rewind for the update sweep.
          if (state == S_SWEEP && cyc == CYC_LAST && op == OP_TRAIN) begin
            cyc           <= '0;
            ram_addr_read <= ADDR0;
            cn_w          <= '0;
            cn_n          <= '0;
            cn_addr       <= ADDR0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    output_f = '0;
    output_b = '0;
    for (int n = 0; n < OUTPUTS; n++) output_f[n*NUM_W +: NUM_W] = activate(p[n]);
    for (int i = 0; i < INPUTS; i++)  output_b[i*NUM_W +: NUM_W] = ob[i];
  end

endmodule

// File: tb/tb_layer_engine.sv
// Testbench for layer_engine (default parameters: 2 inputs, 1 neuron, Q8.8,
// RAM_DELAY 3, clamped leaky ReLU). Includes a latency-accurate RAM model;
// expected results are queued when a command is issued and compared when the
// DUT signals completion.
module tb_layer_engine;

  localparam int NUM_W = 16;
  localparam int D     = 3;
  localparam int LIMIT = 60;

  logic                clk = 1'b0;
  logic                reset, enable, start, ready_in;
  logic [1:0]          cmd;
  logic [2*NUM_W-1:0]  inputs_f;
  logic [NUM_W-1:0]    inputs_b;
  logic [NUM_W-1:0]    output_f;
  logic [2*NUM_W-1:0]  output_b;
  logic [7:0]          ram_addr_read, ram_addr_write;
  logic [NUM_W-1:0]    ram_data_read, ram_data_write;
  logic                ram_write, ready_out, done, sat_flag;

  layer_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd(cmd), .start(start),
    .ready_in(ready_in), .inputs_f(inputs_f), .inputs_b(inputs_b),
    .output_f(output_f), .output_b(output_b), .ram_addr_read(ram_addr_read),
    .ram_data_read(ram_data_read), .ram_write(ram_write),
    .ram_addr_write(ram_addr_write), .ram_data_write(ram_data_write),
    .ready_out(ready_out), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // RAM model: read data appears D enabled cycles after its address and holds
  // while enable is low.
  logic [NUM_W-1:0] mem  [256];
  logic [NUM_W-1:0] pipe [D];
  logic             ld_en = 1'b0;
  logic [7:0]       ld_addr = '0;
  logic [NUM_W-1:0] ld_data = '0;

  assign ram_data_read = pipe[D-1];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_write && enable) mem[ram_addr_write] <= ram_data_write;
    if (enable) begin
      pipe[0] <= mem[ram_addr_read];
      for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
    end
  end

  typedef enum int {OBS_OUTF, OBS_OUTB, OBS_SAT, OBS_SAT_WAIT, OBS_LAT, OBS_WRITES,
                    OBS_MEM0, OBS_MEM1, OBS_MEM2, OBS_READY, OBS_DONE, OBS_RAMWR,
                    OBS_RADDR, OBS_WADDR, OBS_WDATA} obs_e;
  typedef struct {
    obs_e        what;
    logic [31:0] val;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat_obs, writes_obs;
  logic sat_wait_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input obs_e w, input logic [31:0] v);
    exp_t e;
    e.what = w;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input obs_e w);
    case (w)
      OBS_OUTF:     return 32'(output_f);
      OBS_OUTB:     return output_b;
      OBS_SAT:      return 32'(sat_flag);
      OBS_SAT_WAIT: return 32'(sat_wait_obs);
      OBS_LAT:      return 32'(lat_obs);
      OBS_WRITES:   return 32'(writes_obs);
      OBS_MEM0:     return 32'(mem[0]);
      OBS_MEM1:     return 32'(mem[1]);
      OBS_MEM2:     return 32'(mem[2]);
      OBS_READY:    return 32'(ready_out);
      OBS_DONE:     return 32'(done);
      OBS_RAMWR:    return 32'(ram_write);
      OBS_RADDR:    return 32'(ram_addr_read);
      OBS_WADDR:    return 32'(ram_addr_write);
      OBS_WDATA:    return 32'(ram_data_write);
      default:      return '0;
    endcase
  endfunction

  task automatic drain(input string step);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s/%s", step, e.what.name()), observe(e.what), e.val);
    end
  endtask

  task automatic load3(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b);
    logic [15:0] words [3];
    words[0] = w0;
    words[1] = w1;
    words[2] = b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(k);
      ld_data = words[k];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one command; latency is counted from the first SWEEP cycle. Optional
  // enable-low window (5 cycles), stray start pulse, or reset at a given cycle.
  task automatic run_cmd(input logic [1:0] c, input int hold_at, input int poke_at, input int reset_at);
    @(negedge clk);
    cmd      = c;
    start    = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);                 // WAIT
    start        = 1'b0;
    sat_wait_obs = sat_flag;
    @(negedge clk);                 // first SWEEP cycle
    lat_obs    = 0;
    writes_obs = 0;
    while (!done && lat_obs < LIMIT) begin
      if (ram_write && enable) writes_obs++;
      if (lat_obs == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        break;
      end
      start  = (lat_obs == poke_at);
      enable = !(lat_obs >= hold_at && lat_obs < hold_at + 5);
      @(negedge clk);
      lat_obs++;
    end
    start  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic back_to_idle(input string step);
    @(negedge clk);
    check({step, "/idle"}, {30'd0, done, ready_out}, 32'b01);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    start    = 1'b0;
    ready_in = 1'b0;
    cmd      = 2'd0;
    inputs_f = '0;
    inputs_b = '0;
    for (int k = 0; k < D; k++) pipe[k] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    push(OBS_OUTF, 0); push(OBS_OUTB, 0); push(OBS_SAT, 0); push(OBS_READY, 1);
    push(OBS_DONE, 0); push(OBS_RAMWR, 0); push(OBS_RADDR, 0); push(OBS_WADDR, 0);
    push(OBS_WDATA, 0);
    drain("reset");

    // Forward, positive: 2.0*1.0 + 1.0*0.5 + 0.25 = 2.75.
    load3(16'h0100, 16'h0080, 16'h0040);
    inputs_f = {16'h0100, 16'h0200};
    push(OBS_LAT, 7); push(OBS_WRITES, 0); push(OBS_OUTF, 32'h02C0); push(OBS_SAT, 0);
    run_cmd(2'd0, -100, -1, -1);
    drain("fwd_pos");
    back_to_idle("fwd_pos");

    // Gradient only, with a stray start mid-sweep and enable low for 5 cycles.
    inputs_b = 16'h0100;
    push(OBS_LAT, 12); push(OBS_WRITES, 0); push(OBS_OUTB, 32'h0080_0100);
    push(OBS_OUTF, 32'h02C0); push(OBS_SAT, 0);
    run_cmd(2'd1, 3, 1, -1);
    drain("grad_hold");
    back_to_idle("grad_hold");

    // Gradient + update: W += x*e, b += e.
    push(OBS_LAT, 14); push(OBS_WRITES, 3); push(OBS_OUTB, 32'h0080_0100);
    push(OBS_MEM0, 32'h0300); push(OBS_MEM1, 32'h0180); push(OBS_MEM2, 32'h0140);
    push(OBS_SAT, 0);
    run_cmd(2'd2, -100, -1, -1);
    drain("train");
    back_to_idle("train");

    // Forward, negative: p = -4.0 + 0.25 = 0xFC40, leaked by 1/16.
    load3(16'h0100, 16'h0080, 16'h0040);
    inputs_f = {16'h0000, 16'hFC00};
    push(OBS_LAT, 7); push(OBS_OUTF, 32'hFFC4); push(OBS_SAT, 0);
    run_cmd(2'd0, -100, -1, -1);
    drain("fwd_neg");
    back_to_idle("fwd_neg");

    // Gradient on the leaky side: e = 0x0100>>>4 = 0x0010.
    push(OBS_LAT, 7); push(OBS_WRITES, 0); push(OBS_OUTB, 32'h0008_0010);
    run_cmd(2'd1, -100, -1, -1);
    drain("grad_leak");
    back_to_idle("grad_leak");

    // Saturation: 0x7F00*0x7F00 clips to 0x7FFF; clamp above the knee gives 0x0BBF.
    load3(16'h7F00, 16'h0080, 16'h0040);
    inputs_f = {16'h0000, 16'h7F00};
    push(OBS_OUTF, 32'h0BBF); push(OBS_SAT, 1);
    run_cmd(2'd0, -100, -1, -1);
    drain("sat");
    back_to_idle("sat");

    // The next accepted start clears the sticky flag.
    load3(16'h0100, 16'h0080, 16'h0040);
    inputs_f = {16'h0100, 16'h0200};
    push(OBS_SAT_WAIT, 0); push(OBS_SAT, 0); push(OBS_OUTF, 32'h02C0);
    run_cmd(2'd0, -100, -1, -1);
    drain("sat_clear");
    back_to_idle("sat_clear");

    // Reset in the middle of the update write-back.
    push(OBS_WRITES, 2); push(OBS_READY, 1); push(OBS_RAMWR, 0); push(OBS_OUTF, 0);
    push(OBS_OUTB, 0); push(OBS_DONE, 0); push(OBS_SAT, 0);
    run_cmd(2'd2, -100, -1, 12);
    drain("reset_upd");

    // Fresh forward pass: 3*2 + 1.5*1 + 0.25 = 7.75 -> 4 + 3.75/16 = 0x043C.
    load3(16'h0300, 16'h0180, 16'h0040);
    push(OBS_LAT, 7); push(OBS_OUTF, 32'h043C); push(OBS_SAT, 0);
    run_cmd(2'd0, -100, -1, -1);
    drain("after_reset");
    back_to_idle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
